// File: rtl/aes_en_iter.sv
// Iterative AES encryptor: one round per clock, rolling on-the-fly key schedule.
// Byte order is FIPS-197 throughout (bits [127:120] = state byte 0).
module aes_en_iter #(
   parameter int LEN_KEY   = 128,
   parameter int NUM_ROUND = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [127:0]       data_in,
   input  logic [LEN_KEY-1:0] key,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [127:0]       data_out,
   output logic               busy
);

   localparam int NK = LEN_KEY / 32;
   localparam int RW = $clog2(NUM_ROUND + 1);

   if (!((LEN_KEY == 128 && NUM_ROUND == 10) ||
         (LEN_KEY == 192 && NUM_ROUND == 12) ||
         (LEN_KEY == 256 && NUM_ROUND == 14))) begin : g_bad_cfg
      $error("aes_en_iter: illegal LEN_KEY/NUM_ROUND pair");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h00;
      p = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ p;
         p = xt(p);
      end
      return r;
   endfunction

   // S-box as inverse (a^254) followed by the affine map; 0 maps to 0x63.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = b;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) r = gmul(r, p);
         p = gmul(p, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^
             {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input int n);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 1; i < 15; i++) begin
         if (i < n) r = xt(r);
      end
      return r;
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

   fsm_e               state_q, state_d;
   logic [RW-1:0]      rnd_q, rnd_d;
   logic [127:0]       st_q, st_d;
   logic [LEN_KEY-1:0] kw_q, kw_d;
   logic [127:0]       dout_q, dout_d;
   logic [LEN_KEY-1:0] kw_nxt;
   logic [127:0]       rk;
   logic [31:0]        ext [NK+4];
   logic [31:0]        tmp;
   int                 widx;

   // kw_q holds schedule words w[4*rnd .. 4*rnd+NK-1]; each RUN cycle slides it by 4.
   always_comb begin
      tmp  = '0;
      widx = 0;
      for (int j = 0; j < NK; j++) ext[j] = kw_q[LEN_KEY-1-32*j -: 32];
      for (int t = 0; t < 4; t++) begin
         widx = 4 * int'(rnd_q) + NK + t;
         tmp  = ext[NK+t-1];
         if (widx % NK == 0)
            tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon(widx / NK), 24'h0};
         else if (NK > 6 && widx % NK == 4)
            tmp = sub_word(tmp);
         ext[NK+t] = ext[t] ^ tmp;
      end
      kw_nxt = '0;
      for (int j = 0; j < NK; j++) kw_nxt[LEN_KEY-1-32*j -: 32] = ext[j+4];
   end

   assign rk = kw_q[LEN_KEY-1 -: 128];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rnd_q   <= '0;
         st_q    <= '0;
         kw_q    <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         st_q    <= st_d;
         kw_q    <= kw_d;
         dout_q  <= dout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (rnd_q == RW'(NUM_ROUND)) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rnd_d  = rnd_q;
      st_d   = st_q;
      kw_d   = kw_q;
      dout_d = dout_q;
      if (state_q == IDLE && in_valid) begin
         st_d  = data_in;
         kw_d  = key;
         rnd_d = '0;
      end else if (state_q == RUN) begin
         kw_d = kw_nxt;
         if (rnd_q == '0) begin
            st_d  = st_q ^ rk;
            rnd_d = rnd_q + 1'b1;
         end else if (rnd_q == RW'(NUM_ROUND)) begin
            st_d   = sub_shift(st_q) ^ rk;
            dout_d = st_d;
         end else begin
            st_d  = mix(sub_shift(st_q)) ^ rk;
            rnd_d = rnd_q + 1'b1;
         end
      end
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == RUN) || (state_q == DONE);
      data_out  = dout_q;
   end

endmodule
